// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt responder: latches rising request edges into pending
// flags and presents the highest-index enabled source to the CPU, one at a time.
module irq_ctrl #(
  parameter int N   = 3,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   irq,
  input  logic [N-1:0]   irq_en,
  input  logic           int_ack,
  input  logic           eoi,
  output logic           int_req,
  output logic [IDW-1:0] int_id,
  output logic [N-1:0]   int_onehot,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_t;

  state_t         state;
  logic [N-1:0]   irq_prev;
  logic [N-1:0]   rise;
  logic [N-1:0]   cand;
  logic [N-1:0]   clr;
  logic [N-1:0]   win_onehot;
  logic [IDW-1:0] winner;
  logic           ack_fire;

  // int_onehot already holds the decode of int_id while in REQ, so it doubles as the clear mask.
  always_comb begin
    rise       = irq & ~irq_prev;
    cand       = pending & irq_en;
    ack_fire   = (state == REQ) && int_ack;
    clr        = ack_fire ? int_onehot : '0;
    win_onehot = {{(N-1){1'b0}}, 1'b1} << winner;
  end

  // Later indices overwrite earlier ones, so the highest pending index wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) winner = IDW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev <= '0;
      pending  <= '0;
      overrun  <= '0;
    end else begin
      irq_prev <= irq;
      pending  <= (pending & ~clr) | rise;
      overrun  <= overrun | (rise & pending & ~clr);
    end
  end

  // The presented id is frozen for the whole REQ/SVC episode; no re-arbitration until IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_id     <= '0;
      int_onehot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            int_id     <= winner;
            int_onehot <= win_onehot;
            int_req    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            state   <= SVC;
          end else if (!irq_en[int_id]) begin
            int_req    <= 1'b0;
            int_onehot <= '0;
            state      <= IDLE;
          end
        end
        SVC: begin
          if (eoi) begin
            int_onehot <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          int_req    <= 1'b0;
          int_onehot <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
